// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle RV32I-subset datapath: sequences fetch,
// decode, execute, memory and writeback, with a memory-wait watchdog and sticky fault.
module multicycle_control #(
  parameter int unsigned MEM_WAIT_MAX = 15,
  parameter int unsigned CNT_W        = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IorD,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       PCSource,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       RegWrite,
  output logic       MemtoReg,
  output logic       instr_done,
  output logic       fault,
  output logic [1:0] fault_code
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MEM_WAIT_MAX);
  localparam logic [1:0] FC_ILLEGAL = 2'b01;
  localparam logic [1:0] FC_TIMEOUT = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_R_EXEC, S_I_EXEC, S_ALU_WB, S_MEM_ADDR,
    S_MEM_READ, S_LOAD_WB, S_MEM_WRITE, S_BRANCH, S_FAULT
  } state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_d;
  logic [1:0]       fault_code_q, fault_code_d;
  logic             mem_state;
  logic             timeout;

  // The zero flag qualifies PCWriteCond inside the datapath, not here.
  logic unused_zero;
  assign unused_zero = zero;

  assign mem_state  = (state == S_FETCH) || (state == S_MEM_READ) || (state == S_MEM_WRITE);
  assign timeout    = (MEM_WAIT_MAX != 0) && mem_state && !mem_ready && (wait_cnt == WAIT_LIMIT);
  assign fault_code = fault_code_q;

  // State, wait counter and sticky fault code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_FETCH;
      wait_cnt     <= '0;
      fault_code_q <= 2'b00;
    end else begin
      state        <= state_d;
      wait_cnt     <= wait_cnt_d;
      fault_code_q <= fault_code_d;
    end
  end

  // Next state; the counter only runs while a memory state is stalled.
  always_comb begin
    state_d      = state;
    fault_code_d = fault_code_q;
    wait_cnt_d   = (mem_state && !mem_ready) ? wait_cnt + CNT_W'(1) : '0;
    unique case (state)
      S_FETCH, S_MEM_READ, S_MEM_WRITE: begin
        if (mem_ready) begin
          unique case (state)
            S_FETCH:    state_d = S_DECODE;
            S_MEM_READ: state_d = S_LOAD_WB;
            default:    state_d = S_FETCH;
          endcase
        end else if (timeout) begin
          state_d      = S_FAULT;
          fault_code_d = FC_TIMEOUT;
        end
      end
      S_DECODE: begin
        unique case (opcode)
          OP_R:               state_d = S_R_EXEC;
          OP_I:               state_d = S_I_EXEC;
          OP_LOAD, OP_STORE:  state_d = S_MEM_ADDR;
          OP_BRANCH:          state_d = S_BRANCH;
          default: begin
            state_d      = S_FAULT;
            fault_code_d = FC_ILLEGAL;
          end
        endcase
      end
      S_R_EXEC, S_I_EXEC: state_d = S_ALU_WB;
      S_MEM_ADDR:         state_d = (opcode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
      S_ALU_WB, S_LOAD_WB, S_BRANCH: state_d = S_FETCH;
      S_FAULT:            state_d = S_FAULT;
      default:            state_d = S_FETCH;
    endcase
  end

  // Control outputs decoded from state; a few memory-state strobes wait on mem_ready.
  always_comb begin
    mem_req     = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IorD        = 1'b0;
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    PCSource    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    RegWrite    = 1'b0;
    MemtoReg    = 1'b0;
    instr_done  = 1'b0;
    fault       = 1'b0;
    unique case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE: ALUSrcB = 2'b10;
      S_R_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      S_I_EXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = 2'b10;
      end
      S_ALU_WB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEM_READ: begin
        mem_req = 1'b1;
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_LOAD_WB: begin
        RegWrite   = 1'b1;
        MemtoReg   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_req    = 1'b1;
        MemWrite   = 1'b1;
        IorD       = 1'b1;
        instr_done = mem_ready;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 1'b1;
        instr_done  = 1'b1;
      end
      S_FAULT: fault = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multi-cycle RV32I-subset datapath. Sequences the shared ALU, PC, IR, register file and unified memory over several cycles per instruction.
- Drives the 2-bit ALUOp into the existing ALU control decoder (00 = add, 01 = subtract, 10 = decode by funct).
- Handshakes with a variable-latency memory and traps on illegal opcodes or memory timeout.

Parameters:
- MEM_WAIT_MAX, 15: max cycles a memory state may wait for mem_ready before fault; 0 disables the watchdog.
- CNT_W, 4: width of the wait counter; must satisfy 2^CNT_W > MEM_WAIT_MAX.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  7  IR[6:0], valid from DECODE onward.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access request.
- MemRead  out  1  read access.
- MemWrite  out  1  write access.
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- IRWrite  out  1  latch instruction register.
- PCWrite  out  1  unconditional PC update.
- PCWriteCond  out  1  PC update if zero.
- PCSource  out  1  PC source: 0 = ALU result, 1 = ALUOut.
- ALUSrcA  out  1  ALU A: 0 = PC, 1 = reg A.
- ALUSrcB  out  2  ALU B: 00 = reg B, 01 = const 4, 10 = immediate.
- ALUOp  out  2  to ALU control.
- RegWrite  out  1  register file write.
- MemtoReg  out  1  writeback source: 0 = ALUOut, 1 = MDR.
- instr_done  out  1  one-cycle pulse in the last cycle of each instruction.
- fault  out  1  sticky: illegal opcode or memory timeout.
- fault_code  out  2  01 = illegal opcode, 10 = memory timeout, 00 = none.

Behaviour:
- State register uses async reset to FETCH. wait_cnt = 0, fault = 0, fault_code = 00.
- All outputs are combinational from state. Exception: IRWrite, PCWrite and instr_done in memory states are additionally gated by mem_ready, as listed.
- Default for every output is 0 unless listed for the state.

States:
- FETCH: mem_req = 1, MemRead = 1, IorD = 0. When mem_ready: IRWrite = 1, PCWrite = 1, ALUSrcA = 0, ALUSrcB = 01, ALUOp = 00, PCSource = 0, go to DECODE. Otherwise stay.
- DECODE: ALUSrcA = 0, ALUSrcB = 10, ALUOp = 00 (branch target into ALUOut). Next state by opcode:
  - 0110011 -> R_EXEC
  - 0010011 -> I_EXEC
  - 0000011 or 0100011 -> MEM_ADDR
  - 1100011 -> BRANCH
  - any other -> FAULT with code 01
- R_EXEC: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 10 -> ALU_WB.
- I_EXEC: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 10 -> ALU_WB.
- ALU_WB: RegWrite = 1, MemtoReg = 0, instr_done = 1 -> FETCH.
- MEM_ADDR: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00. Load -> MEM_READ, store -> MEM_WRITE.
- MEM_READ: mem_req = 1, MemRead = 1, IorD = 1. When mem_ready -> LOAD_WB.
- LOAD_WB: RegWrite = 1, MemtoReg = 1, instr_done = 1 -> FETCH.
- MEM_WRITE: mem_req = 1, MemWrite = 1, IorD = 1. When mem_ready: instr_done = 1, go to FETCH.
- BRANCH: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 01, PCWriteCond = 1, PCSource = 1, instr_done = 1 -> FETCH.
- FAULT: all control outputs 0 and fault = 1. Stays until rst_n asserted.

Opcode and timing:
- Opcode is sampled only in DECODE and MEM_ADDR; IR holds it stable.
- Cycle counts with zero-wait memory: R/I 4, load 5, store 4, branch 3.
- Each additional memory wait cycle adds 1 to the count.

Watchdog:
- wait_cnt clears on entry to any memory state and increments each cycle mem_ready = 0 in FETCH, MEM_READ or MEM_WRITE.
- If MEM_WAIT_MAX != 0 and wait_cnt == MEM_WAIT_MAX with mem_ready = 0, go to FAULT with code 10.
- mem_ready arriving in that same cycle wins: normal transition, no fault.

Other boundaries:
- mem_ready asserted outside memory states is ignored.
- mem_req stays high and the address select stays stable until mem_ready.
- Reset mid-instruction aborts immediately. Outputs take FETCH values (mem_req = 1, MemRead = 1) combinationally while rst_n is low, and sequencing resumes on the first clk edge after release.
- Reset clears FAULT.

Test Plan:
- rst_n low, release, mem_ready = 1 always, opcode 0110011 -> states FETCH, DECODE, R_EXEC, ALU_WB. ALUOp 00, 00, 10, then RegWrite = 1. instr_done on cycle 4 only.
- Load 0000011 with mem_ready low for 3 cycles in MEM_READ -> 8 cycles total; MemtoReg = 1 and RegWrite = 1 in the final cycle.
- Branch 1100011 -> 3 cycles; in cycle 3 ALUOp = 01, PCWriteCond = 1, PCSource = 1. Check PCWrite stays 0 in that cycle.
- Opcode 1111111 -> fault = 1, fault_code = 01 from cycle 3. Outputs remain 0 for 20 cycles; rst_n pulse returns the FSM to FETCH with fault = 0.
- MEM_WAIT_MAX = 15, mem_ready held low in FETCH -> fault_code = 10 after 15 wait cycles. Repeat with mem_ready on wait cycle 15 -> no fault, DECODE next.
- Store 0100011 with rst_n asserted during MEM_WRITE -> MemWrite drops immediately. After release, FETCH and mem_req = 1.
